// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 Hz timing constants and the 9-bit RRRGGGBBB colour type
// shared by the scanout top and its timing generator.
package vga_pkg;

    localparam int CNT_W = 10;

    // Horizontal line: 640 visible, 16 front porch, 96 sync, 48 back porch.
    localparam logic [CNT_W-1:0] H_VISIBLE    = 10'd640;
    localparam logic [CNT_W-1:0] H_FRONT      = 10'd16;
    localparam logic [CNT_W-1:0] H_SYNC       = 10'd96;
    localparam logic [CNT_W-1:0] H_BACK       = 10'd48;
    localparam logic [CNT_W-1:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [CNT_W-1:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    // Vertical frame: 480 visible, 10 front porch, 2 sync, 33 back porch.
    localparam logic [CNT_W-1:0] V_VISIBLE    = 10'd480;
    localparam logic [CNT_W-1:0] V_FRONT      = 10'd10;
    localparam logic [CNT_W-1:0] V_SYNC       = 10'd2;
    localparam logic [CNT_W-1:0] V_BACK       = 10'd33;
    localparam logic [CNT_W-1:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [CNT_W-1:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Frame buffer image width after pixel doubling.
    localparam int IMG_W = 512;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb9_t;

    // Vertical colour bar: each index bit fans out to a full 3-bit channel.
    function automatic rgb9_t bar_colour(input logic [2:0] idx);
        rgb9_t c;
        c.r = {3{idx[2]}};
        c.g = {3{idx[1]}};
        c.b = {3{idx[0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running 800x525 pixel/line counters with undelayed
// visible, sync, vblank and frame_done decode (stage 0 of the scanout pipe).
module vga_timing
    import vga_pkg::*;
(
    input  logic             vga_clk,
    input  logic             rst,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             h_visible,
    output logic             v_visible,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             vblank,
    output logic             frame_done
);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;

    // Next count: the line counter steps only on the 799->0 wrap, and the
    // (799,524) corner wraps both counters on the same edge.
    always_comb begin
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_TOTAL - 10'd1) begin
            hcount_d = '0;
            if (vcount_q == V_TOTAL - 10'd1) begin
                vcount_d = '0;
            end else begin
                vcount_d = vcount_q + 10'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount     = hcount_q;
    assign vcount     = vcount_q;
    assign h_visible  = (hcount_q < H_VISIBLE);
    assign v_visible  = (vcount_q < V_VISIBLE);
    assign hsync_n    = !((hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END));
    assign vsync_n    = !((vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END));
    assign vblank     = (vcount_q >= V_VISIBLE);
    assign frame_done = (hcount_q == '0) && (vcount_q == V_VISIBLE);

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: frame buffer read side. Generates 640x480@60 timing, walks the
// 256x240 frame buffer 2x2-doubled and centred between H_BORDER-wide borders,
// and registers colour/sync/de onto the DAC pins two cycles after the counters.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_pat input that replaces
// frame buffer data with eight vertical colour bars.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int         H_BORDER   = 64,
    parameter logic [8:0] BORDER_RGB = 9'h000
) (
    input  logic       vga_clk,
    input  logic       rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_pat,
`endif
    input  logic [8:0] rgb,
    output logic [7:0] pix_ptr_x,
    output logic [7:0] pix_ptr_y,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [2:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_de,
    output logic       vblank,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(H_BORDER);
    localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(H_BORDER + IMG_W - 1);

    // Stage 0: timing generator.
    logic [CNT_W-1:0] hcount, vcount;
    logic             h_visible, v_visible, hsync_n, vsync_n;

    vga_timing u_timing (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .hcount     (hcount),
        .vcount     (vcount),
        .h_visible  (h_visible),
        .v_visible  (v_visible),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .vblank     (vblank),
        .frame_done (frame_done)
    );

    // Stage 1 state: frame buffer pointers plus flags delayed to match them.
    logic [7:0] s1_ptr_x_q, s1_ptr_x_d;
    logic [7:0] s1_ptr_y_q, s1_ptr_y_d;
    logic       s1_win_q,   s1_win_d;
    logic       s1_vis_q,   s1_vis_d;
    logic       s1_hs_q,    s1_hs_d;
    logic       s1_vs_q,    s1_vs_d;

    // Stage 2 state: pin registers.
    rgb9_t      s2_rgb_q,   s2_rgb_d;
    logic       s2_hs_q,    s2_hs_d;
    logic       s2_vs_q,    s2_vs_d;
    logic       s2_de_q,    s2_de_d;

    rgb9_t      pix_src;

    // Stage 1 next: halve the window-relative position to get 2x2 doubling;
    // pointers park at 0 outside the image window.
    always_comb begin
        s1_vis_d   = h_visible && v_visible;
        s1_win_d   = v_visible && (hcount >= WIN_LO) && (hcount <= WIN_HI);
        s1_hs_d    = hsync_n;
        s1_vs_d    = vsync_n;
        s1_ptr_x_d = '0;
        s1_ptr_y_d = '0;
        if (s1_win_d) begin
            s1_ptr_x_d = 8'((hcount - WIN_LO) >> 1);
            s1_ptr_y_d = 8'(vcount >> 1);
        end
    end

    // Stage 1 registers; syncs idle high.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            s1_ptr_x_q <= '0;
            s1_ptr_y_q <= '0;
            s1_win_q   <= 1'b0;
            s1_vis_q   <= 1'b0;
            s1_hs_q    <= 1'b1;
            s1_vs_q    <= 1'b1;
        end else begin
            s1_ptr_x_q <= s1_ptr_x_d;
            s1_ptr_y_q <= s1_ptr_y_d;
            s1_win_q   <= s1_win_d;
            s1_vis_q   <= s1_vis_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
        end
    end

    // Image pixel source: frame buffer read data, or colour bars keyed off the
    // same registered pointer so the pattern keeps identical timing.
    always_comb begin
        pix_src = rgb9_t'(rgb);
`ifdef VGA_TEST_PATTERN_EN
        if (test_pat) begin
            pix_src = bar_colour(s1_ptr_x_q[7:5]);
        end
`endif
    end

    // Stage 2 next: image inside the window, border colour in the rest of the
    // visible area, black during blanking.
    always_comb begin
        s2_rgb_d = '0;
        s2_hs_d  = s1_hs_q;
        s2_vs_d  = s1_vs_q;
        s2_de_d  = s1_vis_q;
        if (s1_win_q) begin
            s2_rgb_d = pix_src;
        end else if (s1_vis_q) begin
            s2_rgb_d = rgb9_t'(BORDER_RGB);
        end
    end

    // Stage 2 registers drive the pins directly.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            s2_rgb_q <= '0;
            s2_hs_q  <= 1'b1;
            s2_vs_q  <= 1'b1;
            s2_de_q  <= 1'b0;
        end else begin
            s2_rgb_q <= s2_rgb_d;
            s2_hs_q  <= s2_hs_d;
            s2_vs_q  <= s2_vs_d;
            s2_de_q  <= s2_de_d;
        end
    end

    assign pix_ptr_x = s1_ptr_x_q;
    assign pix_ptr_y = s1_ptr_y_q;
    assign vga_r     = s2_rgb_q.r;
    assign vga_g     = s2_rgb_q.g;
    assign vga_b     = s2_rgb_q.b;
    assign vga_hs    = s2_hs_q;
    assign vga_vs    = s2_vs_q;
    assign vga_de    = s2_de_q;

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Read side of the VGA frame buffer: generates 640x480@60 Hz VGA timing, addresses the frame buffer pixel-by-pixel with `pix_ptr_x`/`pix_ptr_y`, and drives the DAC pins with aligned RRRGGGBBB colour. It sits between the frame buffer's read port and the board's VGA connector. The 256x240 PPU image is line- and pixel-doubled to 512x480 and centred horizontally with black borders.

## Interface
- `H_BORDER`, default 64: black columns on each side of the 512-pixel image.
- `BORDER_RGB`, default 9'h000: colour driven in border columns.
- `vga_clk`  in  1  pixel clock, 25.175 MHz nominal; one cycle equals one pixel.
- `rst`  in  1  reset, asynchronous, active-high.
- `rgb`  in  9  frame buffer read data, RRRGGGBBB, combinational from `pix_ptr_x`/`pix_ptr_y`.
- `pix_ptr_x`  out  8  frame buffer column, 0..255.
- `pix_ptr_y`  out  8  frame buffer row, 0..239.
- `vga_r`, `vga_g`, `vga_b`  out  3 each  DAC colour.
- `vga_hs`, `vga_vs`  out  1  syncs, active-low.
- `vga_de`  out  1  active-video flag, aligned with colour.
- `vblank`  out  1  high while `vcount` >= 480, undelayed.
- `frame_done`  out  1  one-cycle pulse on `vga_clk` when `hcount`==0 and `vcount`==480.

## Operation
- Horizontal counter `hcount` runs 0..799: 640 visible, 16 front porch, 96 sync (656..751), 48 back porch.
- Vertical counter `vcount` runs 0..524 and increments when `hcount` wraps 799->0: 480 visible, 10 front porch, 2 sync (490..491), 33 back porch. `vcount` wraps 524->0 on the same edge.
- Image window: `hcount` in [H_BORDER, H_BORDER+511] and `vcount` < 480.
- `pix_ptr_x` = (hcount-H_BORDER)>>1, truncated to 8 bits. `pix_ptr_y` = vcount>>1. Each frame buffer pixel is shown 2x2.
- Outside the window, pointers hold 0. Colour = BORDER_RGB inside visible area but outside the window, 0 outside the visible area.
- Colour split: `vga_r`=rgb[8:6], `vga_g`=rgb[5:3], `vga_b`=rgb[2:0].
- The block never writes the frame buffer. PPU writes are asynchronous to this block, so tearing is accepted.

## Timing
- Stage 0: counters. Stage 1: registered pointers plus delayed window/visible/sync flags. Stage 2: registered colour sampled from `rgb` plus sync/de.
- Pin latency: counter value n appears on `vga_*` 2 cycles later. Sync, de and colour are mutually aligned, and sync widths are exact (96 and 2 cycles).
- Reset values:
  - Counters 0; all pipeline registers cleared.
  - `vga_hs`=`vga_vs`=1, `vga_de`=0, colour 0, pointers 0.
  - `vblank`=0, `frame_done`=0.
- Reset mid-frame: all outputs return to reset values immediately (async). The first active pixel reaches the pins 2 cycles after `rst` deasserts.
- Double wrap at (799,524): both counters go to 0 on one edge, and no extra line is inserted.

## Configuration
- `VGA_TEST_PATTERN_EN` defined:
  - Adds input `test_pat` (1 bit).
  - When `test_pat`=1, stage-2 colour is eight vertical bars, 64 pixels each, over the 512-pixel window. Bar index = pix_ptr_x[7:5]; colour = {3{idx[2]},3{idx[1]},3{idx[0]}}.
  - `rgb` is ignored in this mode; timing is unchanged.
- Undefined: no `test_pat` port, and colour always comes from `rgb`.

## Structure
- `vga_pkg`: H/V visible, porch, sync and total constants; a `rgb9_t` packed struct {r,g,b}.
- Sub-module `vga_timing`: counters, sync/visible decode, `vblank`, `frame_done`. The top level holds pointer and colour pipelines.

## Test plan
- Reset release, count 800x525 cycles:
  - `vga_hs` low exactly 96 cycles per line, first at cycle 656+2.
  - `vga_vs` low for 1600 cycles, starting on line 490.
  - `frame_done` pulses once per 420000 cycles.
- Frame buffer model returns rgb={x[7:0],y[0]} style pattern:
  - At `hcount`=64 and 65, `pix_ptr_x`=0; at `hcount`=575, `pix_ptr_x`=255.
  - Lines 2 and 3 both give `pix_ptr_y`=1.
  - Colour at pins matches the model value 2 cycles later.
- BORDER_RGB=9'h1C7: columns 0..63 and 576..639 show r=7,g=0,b=7 with `vga_de`=1. During blanking, colour is 0 and `vga_de`=0.
- Assert `rst` at `hcount`=300, `vcount`=100 for 3 cycles:
  - Outputs go to reset values asynchronously.
  - After release, `hcount` restarts at 0 and the first visible pixel appears 2 cycles later.
- `VGA_TEST_PATTERN_EN` with `test_pat`=1: pin colour is 0 at `hcount`=64 and 9'h1FF at `hcount`=575. Each bar is 64 pixels wide.
- Wrap check: at (799,524)->(0,0), both counters wrap on one edge. `vblank` falls at `vcount`=0 and rises at `vcount`=480.
